unpool: RTL
===========

# unpool

Nearest-neighbour POOL×POOL upsampler over BRAM: reads each element of a pooled feature map (CHANNELS × IN_SIZE × IN_SIZE, channel-major) and writes it into a POOL×POOL block of an expanded buffer (CHANNELS × OUT_SIZE × OUT_SIZE, OUT_SIZE = IN_SIZE·POOL). It is the read-side/inverse counterpart of the 2×2 max-pool stage. It is used for decoder/upsampling paths and for broadcasting pooled values back to conv resolution. One start/done transaction processes the whole tensor.

## Interface
- DATA_WIDTH, 16, signed element width
- CHANNELS, 8, feature-map channels
- IN_SIZE, 14, input (pooled) height = width
- POOL, 2, upsample factor per axis (≥1)
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin transaction; sampled only in IDLE
- in_addr  out  $clog2(CHANNELS·IN_SIZE²)  read address into pooled buffer
- in_en  out  1  read enable, pooled buffer
- in_q  in  DATA_WIDTH signed  read data; valid the cycle after in_en is high
- out_addr  out  $clog2(CHANNELS·OUT_SIZE²)  write address into expanded buffer
- out_en  out  1  expanded buffer enable
- out_we  out  1  expanded buffer write enable
- out_d  out  DATA_WIDTH signed  write data
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle completion pulse

## Operation
- All outputs registered; linear index lin3(ch,row,col,H,W) = (ch·H+row)·W+col.
- FSM states: IDLE, WAIT, CAPTURE, WRITE, FINISH.
- IDLE: on start, clear ch/r/c/dy/dx, issue in_addr=lin3(0,0,0,IN,IN), in_en=1 → WAIT.
- WAIT: in_en low; BRAM read in flight → CAPTURE.
- CAPTURE: latch in_q into hold register v → WRITE.
- WRITE: one cycle per (dy,dx), dx fastest, dy 0..POOL-1: out_addr=lin3(ch, r·POOL+dy, c·POOL+dx, OUT,OUT), out_d=v, out_en=out_we=1.
- Last (dy,dx) of a pixel: advance c, then r, then ch (wrap each at IN_SIZE-1 / CHANNELS-1); if more pixels remain, issue next in_addr with in_en=1 in the same cycle → WAIT; else → FINISH.
- FINISH: done=1 for exactly this cycle → IDLE.
- start while busy ignored; start held high in IDLE relaunches after FINISH.
- out_en/out_we/in_en deasserted every cycle not listed above; out_addr/out_d/in_addr hold last value when not enabled.
- No arithmetic on data; values pass bit-exact (sign preserved).

## Timing
- Reset values: in_addr=0, in_en=0, out_addr=0, out_en=0, out_we=0, out_d=0, busy=0, done=0, state=IDLE, counters and v=0.
- reset_n low mid-transaction: immediate return to reset values; no further writes; next transaction requires new start.
- Per input pixel: 2 + POOL² cycles (WAIT, CAPTURE, POOL² WRITE).
- Cycle 1 = first cycle after start sampled; done high in cycle N·(2+POOL²)+1, N = CHANNELS·IN_SIZE².
- Exactly CHANNELS·OUT_SIZE² writes per transaction, each address written once, ascending within a POOL-block, blocks in raster order per channel.
- POOL=1: one write per pixel, out_addr equals source address.

## Configuration
- UNPOOL_ZERO_FILL_EN defined: zero-insertion upsampling — (dy,dx)=(0,0) writes v, all other positions write 0; write count, order and timing unchanged.
- Undefined: every position of the POOL×POOL block writes v (replication).

## Test plan
- CHANNELS=2, IN_SIZE=2, POOL=2, in buffer = index+1 (1..8): after start, out buffer channel 0 rows = [1,1,2,2],[1,1,2,2],[3,3,4,4],[3,3,4,4]; channel 1 same with 5..8; done at cycle 49, single-cycle pulse.
- Same config, in values −32768 and 32767 at indices 0 and 7 → out addresses 0,1,4,5 = −32768; 26,27,30,31 = 32767.
- UNPOOL_ZERO_FILL_EN defined, values 1..8 → out[0]=1, out[1]=out[4]=out[5]=0, out[2]=2; 32 writes total.
- start pulsed again at cycle 10 while busy → ignored; done pulses once at 49; write count 32.
- reset_n low at cycle 20 → all outputs 0 asynchronously, busy=0; no writes after; new start completes normally with done at cycle 49.
- POOL=1, CHANNELS=1, IN_SIZE=3 → 9 writes, out_addr = in_addr sequence 0..8, done at cycle 28.

Source files
------------

// File: rtl/unpool.sv
// Nearest-neighbour POOL x POOL upsampler between two BRAMs, one start/done pass per tensor.
// Define UNPOOL_ZERO_FILL_EN for zero-insertion (value only at block origin) instead of replication.
module unpool #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CHANNELS   = 8,
  parameter int unsigned IN_SIZE    = 14,
  parameter int unsigned POOL       = 2,
  localparam int unsigned OutSize  = IN_SIZE * POOL,
  localparam int unsigned InDepth  = CHANNELS * IN_SIZE * IN_SIZE,
  localparam int unsigned OutDepth = CHANNELS * OutSize * OutSize,
  localparam int unsigned InAw     = (InDepth > 1) ? $clog2(InDepth) : 1,
  localparam int unsigned OutAw    = (OutDepth > 1) ? $clog2(OutDepth) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  output logic [InAw-1:0]              in_addr,
  output logic                         in_en,
  input  logic signed [DATA_WIDTH-1:0] in_q,
  output logic [OutAw-1:0]             out_addr,
  output logic                         out_en,
  output logic                         out_we,
  output logic signed [DATA_WIDTH-1:0] out_d,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned ChW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned RcW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam int unsigned PW  = (POOL > 1) ? $clog2(POOL) : 1;

  typedef enum logic [2:0] {StIdle, StWait, StCapture, StWrite, StFinish} state_e;

  state_e                        state_q, state_d;
  logic [ChW-1:0]                ch_q, ch_d;
  logic [RcW-1:0]                r_q, r_d, c_q, c_d;
  logic [PW-1:0]                 dy_q, dy_d, dx_q, dx_d;
  logic signed [DATA_WIDTH-1:0]  v_q, v_d;
  logic [InAw-1:0]               in_addr_q, in_addr_d;
  logic                          in_en_q, in_en_d;
  logic [OutAw-1:0]              out_addr_q, out_addr_d;
  logic                          out_en_q, out_en_d;
  logic                          out_we_q, out_we_d;
  logic signed [DATA_WIDTH-1:0]  out_d_q, out_d_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic [PW-1:0]                 ndx, ndy;
  logic                          blk_last, pix_last;

  function automatic logic [InAw-1:0] in_lin(input int unsigned ch, input int unsigned r,
                                             input int unsigned c);
    int unsigned a;
    a = (ch * IN_SIZE + r) * IN_SIZE + c;
    return InAw'(a);
  endfunction

  function automatic logic [OutAw-1:0] out_lin(input int unsigned ch, input int unsigned row,
                                               input int unsigned col);
    int unsigned a;
    a = (ch * OutSize + row) * OutSize + col;
    return OutAw'(a);
  endfunction

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    r_d        = r_q;
    c_d        = c_q;
    dy_d       = dy_q;
    dx_d       = dx_q;
    v_d        = v_q;
    in_addr_d  = in_addr_q;
    in_en_d    = 1'b0;
    out_addr_d = out_addr_q;
    out_en_d   = 1'b0;
    out_we_d   = 1'b0;
    out_d_d    = out_d_q;
    done_d     = 1'b0;
    ndx        = dx_q;
    ndy        = dy_q;
    blk_last   = (dx_q == PW'(POOL - 1)) && (dy_q == PW'(POOL - 1));
    pix_last   = (c_q == RcW'(IN_SIZE - 1)) && (r_q == RcW'(IN_SIZE - 1)) &&
                 (ch_q == ChW'(CHANNELS - 1));

    unique case (state_q)
      StIdle: begin
        if (start) begin
          ch_d      = '0;
          r_d       = '0;
          c_d       = '0;
          dy_d      = '0;
          dx_d      = '0;
          in_addr_d = '0;
          in_en_d   = 1'b1;
          state_d   = StWait;
        end
      end
      StWait: state_d = StCapture;
      StCapture: begin
        // First write of the block is issued here so it lands in the first WRITE cycle.
        v_d        = in_q;
        out_en_d   = 1'b1;
        out_we_d   = 1'b1;
        out_addr_d = out_lin(32'(ch_q), 32'(r_q) * POOL, 32'(c_q) * POOL);
        out_d_d    = in_q;
        state_d    = StWrite;
      end
      StWrite: begin
        if (blk_last) begin
          dx_d = '0;
          dy_d = '0;
          if (c_q == RcW'(IN_SIZE - 1)) begin
            c_d = '0;
            if (r_q == RcW'(IN_SIZE - 1)) begin
              r_d  = '0;
              ch_d = (ch_q == ChW'(CHANNELS - 1)) ? '0 : ch_q + ChW'(1);
            end else begin
              r_d = r_q + RcW'(1);
            end
          end else begin
            c_d = c_q + RcW'(1);
          end
          if (pix_last) begin
            done_d  = 1'b1;
            state_d = StFinish;
          end else begin
            in_addr_d = in_lin(32'(ch_d), 32'(r_d), 32'(c_d));
            in_en_d   = 1'b1;
            state_d   = StWait;
          end
        end else begin
          if (dx_q == PW'(POOL - 1)) begin
            ndx = '0;
            ndy = dy_q + PW'(1);
          end else begin
            ndx = dx_q + PW'(1);
          end
          dx_d       = ndx;
          dy_d       = ndy;
          out_en_d   = 1'b1;
          out_we_d   = 1'b1;
          out_addr_d = out_lin(32'(ch_q), 32'(r_q) * POOL + 32'(ndy),
                               32'(c_q) * POOL + 32'(ndx));
`ifdef UNPOOL_ZERO_FILL_EN
          out_d_d    = (ndx == '0 && ndy == '0) ? v_q : '0;
`else
          out_d_d    = v_q;
`endif
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      ch_q       <= '0;
      r_q        <= '0;
      c_q        <= '0;
      dy_q       <= '0;
      dx_q       <= '0;
      v_q        <= '0;
      in_addr_q  <= '0;
      in_en_q    <= 1'b0;
      out_addr_q <= '0;
      out_en_q   <= 1'b0;
      out_we_q   <= 1'b0;
      out_d_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      r_q        <= r_d;
      c_q        <= c_d;
      dy_q       <= dy_d;
      dx_q       <= dx_d;
      v_q        <= v_d;
      in_addr_q  <= in_addr_d;
      in_en_q    <= in_en_d;
      out_addr_q <= out_addr_d;
      out_en_q   <= out_en_d;
      out_we_q   <= out_we_d;
      out_d_q    <= out_d_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_addr  = in_addr_q;
  assign in_en    = in_en_q;
  assign out_addr = out_addr_q;
  assign out_en   = out_en_q;
  assign out_we   = out_we_q;
  assign out_d    = out_d_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
